prog_down_counter: RTL and testbench
====================================

// Module: prog_down_counter
// PURPOSE
//  Parametrised, loadable down counter/timer with prescaler and three count modes
//  (free-run wrap, auto-reload, one-shot), start/stop control and terminal-count pulse.
//  Next-generation general counter for timer/delay generation; drives event strobes into
//  downstream FSMs. Single clock domain.
// PARAMETERS
//  WIDTH       8  counter and load-value width (>=2)
//  PRESCALE_W  4  prescaler select width; tick period = prescale+1 clocks
// PORTS
//  clk       in   1           system clock, all logic on rising edge
//  reset_n   in   1           synchronous reset, active-low
//  load      in   1           load load_val into count and reload register
//  load_val  in   WIDTH       value for load
//  start     in   1           IDLE/DONE -> RUN
//  stop      in   1           RUN -> IDLE, count held
//  mode      in   2           00 free-run, 01 auto-reload, 10/11 one-shot
//  prescale  in   PRESCALE_W  tick divider select
//  count     out  WIDTH       current count (registered)
//  tc        out  1           terminal-count pulse, one clock wide (registered)
//  busy      out  1           1 while state==RUN
//  done      out  1           one-shot expiry flag, sticky
// BEHAVIOUR
//  Clock/reset: one clock clk; reset_n synchronous active-low, sampled on rising edge.
//  Reset (reset_n=0 at edge): count=0, reload=0, prescaler cnt=0, state=IDLE, tc=0,
//   busy=0, done=0; overrides all inputs. Mid-operation reset aborts at that edge.
//  States: IDLE (hold), RUN (counting), DONE (one-shot expired, count holds 0).
//  Priority per edge: reset > load > stop > start > tick.
//  load=1: count<=load_val, reload<=load_val, prescaler<=0, done<=0, tc<=0;
//   DONE->IDLE, IDLE/RUN unchanged. Pending tick that cycle is discarded.
//  stop=1 in RUN: ->IDLE, count/reload held, prescaler<=0. stop+start same cycle: stop wins.
//  start=1 in IDLE/DONE: ->RUN, prescaler<=0, done<=0. Ignored in RUN.
//  Prescaler (RUN only): tick when pcnt==prescale; then pcnt<=0, else pcnt<=pcnt+1.
//   prescale=0 -> tick every clock in RUN. prescale sampled every cycle.
//  On tick with count!=0: count<=count-1 (mod 2^WIDTH), tc<=0.
//  On tick with count==0 (terminal): tc<=1 for exactly one clock, and
//   00 free-run: count<=2^WIDTH-1, stay RUN
//   01 auto-reload: count<=reload, stay RUN (reload=0 -> tc on every tick)
//   1x one-shot: count stays 0, ->DONE, done<=1, busy<=0
//  mode sampled at each tick; a change mid-run acts at the next terminal.
//  Terminal period = (reload+1)*(prescale+1) clocks in auto-reload.
//  Latency: first decrement at edge (prescale+1) after the start edge.
//  tc=0 on every cycle without a terminal tick; busy registered from next state.
//  done stays 1 until load, start or reset.
// TESTING
//  1 reset_n=0 two clocks with load=start=1 -> count=0, tc=0, busy=0, done=0.
//  2 WIDTH=8, load 5, mode=10, prescale=0, start -> count 5,4,3,2,1,0 on successive
//    edges; next edge tc=1 for 1 clk, done=1, busy=0, count holds 0.
//  3 load 3, mode=01, prescale=2, start -> each value 3..0 held 3 clks;
//    tc every 12 clks, count returns to 3 after each tc.
//  4 load 1, mode=00, prescale=0, start -> 1,0,255,254...; tc=1 only on 0->255 step.
//  5 RUN at count 7: stop -> IDLE, count=7 holds; start -> resumes 6,5...;
//    start+stop same cycle in RUN -> IDLE.
//  6 load 9 in RUN on a terminal tick -> count=9, tc=0, stays RUN; reset_n=0 mid-run
//    -> all outputs at reset values next edge.

Source files
------------

// File: rtl/prog_down_counter.sv
// Loadable down counter/timer with prescaler, free-run / auto-reload / one-shot modes,
// start/stop control, a one-clock terminal-count pulse and a sticky one-shot done flag.
module prog_down_counter #(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic                  start,
    input  logic                  stop,
    input  logic [1:0]            mode,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  busy,
    output logic                  done
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [1:0] MODE_FREE   = 2'b00;
    localparam logic [1:0] MODE_RELOAD = 2'b01;

    logic [1:0]            state_q,  state_d;
    logic [WIDTH-1:0]      count_q,  count_d;
    logic [WIDTH-1:0]      reload_q, reload_d;
    logic [PRESCALE_W-1:0] pcnt_q,   pcnt_d;
    logic                  tc_q,     tc_d;
    logic                  done_q,   done_d;
    logic                  busy_q;
    logic                  running;
    logic                  tick;

    assign running = (state_q == ST_RUN);
    assign tick    = running && (pcnt_q == prescale);

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        pcnt_d   = pcnt_q;
        tc_d     = 1'b0;
        done_d   = done_q;

        // Recover from the unused state encoding.
        if (state_q != ST_IDLE && state_q != ST_RUN && state_q != ST_DONE) begin
            state_d = ST_IDLE;
        end

        if (load) begin
            // A tick falling on the load cycle is discarded.
            count_d  = load_val;
            reload_d = load_val;
            pcnt_d   = '0;
            done_d   = 1'b0;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else if (stop) begin
            // Stop outranks start, so a simultaneous start never restarts the timer.
            pcnt_d = '0;
            if (running) begin
                state_d = ST_IDLE;
            end
        end else if (start && !running) begin
            state_d = ST_RUN;
            pcnt_d  = '0;
            done_d  = 1'b0;
        end else if (running) begin
            if (tick) begin
                pcnt_d = '0;
                if (count_q != '0) begin
                    count_d = count_q - 1'b1;
                end else begin
                    tc_d = 1'b1;
                    if (mode == MODE_FREE) begin
                        count_d = '1;
                    end else if (mode == MODE_RELOAD) begin
                        count_d = reload_q;
                    end else begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end
                end
            end else begin
                pcnt_d = pcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            pcnt_q   <= '0;
            tc_q     <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            pcnt_q   <= pcnt_d;
            tc_q     <= tc_d;
            done_q   <= done_d;
            busy_q   <= (state_d == ST_RUN);
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign busy  = busy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_prog_down_counter.sv
// Bench for prog_down_counter: directed scenarios with literal expectations plus
// randomized traffic, all checked each cycle against a behavioural model.
module tb_prog_down_counter;

    localparam int W   = 8;
    localparam int PW  = 4;
    localparam int MAXC = (1 << W) - 1;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          load;
    logic [W-1:0]  load_val;
    logic          start;
    logic          stop;
    logic [1:0]    mode;
    logic [PW-1:0] prescale;
    logic [W-1:0]  count;
    logic          tc;
    logic          busy;
    logic          done;

    int n_cmp = 0;
    int n_bad = 0;

    prog_down_counter #(.WIDTH(W), .PRESCALE_W(PW)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load),
        .load_val (load_val),
        .start    (start),
        .stop     (stop),
        .mode     (mode),
        .prescale (prescale),
        .count    (count),
        .tc       (tc),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a timer that is either running or not, may have expired,
    // and counts clocks between ticks.
    int m_count, m_reload, m_phase;
    bit m_run, m_expired, m_tc, m_valid = 0;

    always @(posedge clk) begin
        m_valid = 1;
        if (!reset_n) begin
            m_count = 0; m_reload = 0; m_phase = 0;
            m_run = 0; m_expired = 0; m_tc = 0;
        end else begin
            m_tc = 0;
            if (load) begin
                m_count = load_val; m_reload = load_val;
                m_phase = 0; m_expired = 0;
            end else if (stop) begin
                m_run = 0; m_phase = 0;
            end else if (start && !m_run) begin
                m_run = 1; m_phase = 0; m_expired = 0;
            end else if (m_run) begin
                if (m_phase == int'(prescale)) begin
                    m_phase = 0;
                    if (m_count > 0) begin
                        m_count = m_count - 1;
                    end else begin
                        m_tc = 1;
                        case (mode)
                            2'b00:   m_count = MAXC;
                            2'b01:   m_count = m_reload;
                            default: begin m_run = 0; m_expired = 1; end
                        endcase
                    end
                end else begin
                    m_phase = (m_phase + 1) % (1 << PW);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_count", int'(count), m_count);
            chk("model_tc",    int'(tc),    int'(m_tc));
            chk("model_busy",  int'(busy),  int'(m_run));
            chk("model_done",  int'(done),  int'(m_expired));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string name, input int c, input int t, input int b, input int d);
        chk({name, "_count"}, int'(count), c);
        chk({name, "_tc"},    int'(tc),    t);
        chk({name, "_busy"},  int'(busy),  b);
        chk({name, "_done"},  int'(done),  d);
    endtask

    initial begin
        reset_n = 0; load = 1; start = 1; stop = 0;
        load_val = 8'd77; mode = 2'b00; prescale = '0;

        // Reset overrides load and start.
        step(); step();
        outs("reset", 0, 0, 0, 0);
        reset_n = 1; load = 0; start = 0;

        // One-shot, prescale 0.
        load = 1; load_val = 8'd5; mode = 2'b10; prescale = 4'd0;
        step(); load = 0;
        outs("os_load", 5, 0, 0, 0);
        start = 1; step(); start = 0;
        outs("os_start", 5, 0, 1, 0);
        for (int k = 4; k >= 0; k--) begin
            step();
            outs("os_dec", k, 0, 1, 0);
        end
        step(); outs("os_term", 0, 1, 0, 1);
        step(); outs("os_hold", 0, 0, 0, 1);

        // Auto-reload, prescale 2: period 12 clocks.
        load = 1; load_val = 8'd3; mode = 2'b01; prescale = 4'd2;
        step(); load = 0;
        outs("ar_load", 3, 0, 0, 0);
        start = 1; step(); start = 0;
        outs("ar_start", 3, 0, 1, 0);
        for (int i = 1; i <= 24; i++) begin
            step();
            outs("ar_run", 3 - ((i / 3) % 4), (i % 12 == 0) ? 1 : 0, 1, 0);
        end

        // Free-run wrap.
        load = 1; load_val = 8'd1; mode = 2'b00; prescale = 4'd0;
        step(); load = 0;
        outs("fr_load", 1, 0, 1, 0);
        step(); outs("fr_0",   0,   0, 1, 0);
        step(); outs("fr_255", 255, 1, 1, 0);
        step(); outs("fr_254", 254, 0, 1, 0);
        step(); outs("fr_253", 253, 0, 1, 0);

        // Stop, resume, and start+stop together.
        load = 1; load_val = 8'd8;
        step(); load = 0;
        outs("ss_load", 8, 0, 1, 0);
        step(); outs("ss_7", 7, 0, 1, 0);
        stop = 1; step(); stop = 0;
        outs("ss_stop", 7, 0, 0, 0);
        repeat (3) step();
        outs("ss_held", 7, 0, 0, 0);
        start = 1; step(); start = 0;
        outs("ss_resume", 7, 0, 1, 0);
        step(); outs("ss_6", 6, 0, 1, 0);
        step(); outs("ss_5", 5, 0, 1, 0);
        start = 1; stop = 1; step(); start = 0; stop = 0;
        outs("ss_both", 5, 0, 0, 0);

        // Load on a terminal tick, then reset mid-run.
        load = 1; load_val = 8'd0; mode = 2'b01;
        step(); load = 0;
        start = 1; step(); start = 0;
        outs("lt_start", 0, 0, 1, 0);
        load = 1; load_val = 8'd9; step(); load = 0;
        outs("lt_load", 9, 0, 1, 0);
        step(); outs("lt_8", 8, 0, 1, 0);
        reset_n = 0; step(); reset_n = 1;
        outs("mid_reset", 0, 0, 0, 0);

        // Randomized traffic checked by the model only.
        for (int i = 0; i < 4000; i++) begin
            reset_n  = ($urandom_range(0, 299) != 0);
            load     = ($urandom_range(0, 24) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            start    = ($urandom_range(0, 7) == 0);
            mode     = 2'($urandom_range(0, 3));
            prescale = ($urandom_range(0, 3) == 0) ? PW'($urandom) : PW'($urandom_range(0, 2));
            load_val = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 6)) : W'($urandom);
            step();
        end
        reset_n = 1; load = 0; stop = 0; start = 0;
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
